// File: rtl/soc_system_chaos_engine.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_chaos_engine
// Purpose  : Fixed-point logistic-map accelerator, x' = r*x*(1-x), with an
//            Avalon-MM register slave and a sticky done level for a PIO.
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_chaos_engine (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        done,
    output logic        busy,
    output logic [15:0] x_out,
    output logic        x_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC1 = 2'd1,
        S_CALC2 = 2'd2
    } state_t;

    localparam logic [2:0] C_ADDR_CTRL   = 3'd0;
    localparam logic [2:0] C_ADDR_X0     = 3'd1;
    localparam logic [2:0] C_ADDR_R      = 3'd2;
    localparam logic [2:0] C_ADDR_COUNT  = 3'd3;
    localparam logic [2:0] C_ADDR_RESULT = 3'd4;
    localparam logic [2:0] C_ADDR_ITER   = 3'd5;

    state_t      state_q, state_d;
    logic [15:0] x0_q, r_q, count_q;
    logic [15:0] xw_q, xw_d;
    logic [15:0] rw_q, rw_d;
    logic [15:0] nw_q, nw_d;
    logic [15:0] iter_q, iter_d;
    logic [15:0] t_q, t_d;
    logic        done_q, done_d;
    logic        xvalid_q, xvalid_d;
    logic [31:0] readdata_q, readdata_d;

    logic        w_wr;
    logic        w_start;
    logic        w_clr;
    logic [16:0] w_one_minus_x;
    logic [32:0] w_prod_t;
    logic [31:0] w_prod_p;
    logic        w_unused;

    assign w_wr    = chipselect && !write_n;
    assign w_start = w_wr && (address == C_ADDR_CTRL) && writedata[0];
    assign w_clr   = w_wr && (address == C_ADDR_CTRL) && writedata[1];

    // x*(1-x) never exceeds 2^30 and r*t stays below 2^30, so the slices
    // below are exact and no saturation is needed.
    assign w_one_minus_x = 17'h10000 - {1'b0, xw_q};
    assign w_prod_t      = 33'(xw_q) * 33'(w_one_minus_x);
    assign w_prod_p      = 32'(rw_q) * 32'(t_q);

    assign w_unused = ^{w_prod_t[32], w_prod_t[15:0], w_prod_p[31:30],
                        w_prod_p[13:0], writedata[31:16]};

    // Host-visible configuration registers; the running job uses copies.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x0_q    <= 16'd0;
            r_q     <= 16'd0;
            count_q <= 16'd0;
        end else if (w_wr) begin
            case (address)
                C_ADDR_X0:    x0_q    <= writedata[15:0];
                C_ADDR_R:     r_q     <= writedata[15:0];
                C_ADDR_COUNT: count_q <= writedata[15:0];
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            xw_q       <= 16'd0;
            rw_q       <= 16'd0;
            nw_q       <= 16'd0;
            iter_q     <= 16'd0;
            t_q        <= 16'd0;
            done_q     <= 1'b0;
            xvalid_q   <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            xw_q       <= xw_d;
            rw_q       <= rw_d;
            nw_q       <= nw_d;
            iter_q     <= iter_d;
            t_q        <= t_d;
            done_q     <= done_d;
            xvalid_q   <= xvalid_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        xw_d     = xw_q;
        rw_d     = rw_q;
        nw_d     = nw_q;
        iter_d   = iter_q;
        t_d      = t_q;
        done_d   = done_q;
        xvalid_d = 1'b0;

        // An accepted START below overrides this clear.
        if (w_clr) begin
            done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    xw_d   = x0_q;
                    rw_d   = r_q;
                    nw_d   = count_q;
                    iter_d = 16'd0;
                    if (count_q == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        state_d = S_CALC1;
                    end
                end
            end
            S_CALC1: begin
                t_d     = w_prod_t[31:16];
                state_d = S_CALC2;
            end
            S_CALC2: begin
                xw_d     = w_prod_p[29:14];
                iter_d   = iter_q + 16'd1;
                xvalid_d = 1'b1;
                if ((iter_q + 16'd1) == nw_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CALC1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        readdata_d = 32'd0;
        case (address)
            C_ADDR_CTRL:   readdata_d = {30'd0, busy, done_q};
            C_ADDR_X0:     readdata_d = {16'd0, x0_q};
            C_ADDR_R:      readdata_d = {16'd0, r_q};
            C_ADDR_COUNT:  readdata_d = {16'd0, count_q};
            C_ADDR_RESULT: readdata_d = {16'd0, xw_q};
            C_ADDR_ITER:   readdata_d = {16'd0, iter_q};
            default:       readdata_d = 32'd0;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign x_out    = xw_q;
    assign x_valid  = xvalid_q;
    assign readdata = readdata_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_chaos_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_chaos_engine
// Purpose  : Self-checking bench for the logistic-map accelerator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_system_chaos_engine;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        done;
    logic        busy;
    logic [15:0] x_out;
    logic        x_valid;

    int errors = 0;
    int checks = 0;

    // Per-cycle {busy, x_valid, done, x_out}, index k = cycles after START edge.
    logic [18:0] obs_v [1:64];
    logic [18:0] exp_v [1:64];

    soc_system_chaos_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .done       (done),
        .busy       (busy),
        .x_out      (x_out),
        .x_valid    (x_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic setup_run(input logic [15:0] x0, input logic [15:0] r, input logic [15:0] n);
        bus_write(3'd1, {16'd0, x0});
        bus_write(3'd2, {16'd0, r});
        bus_write(3'd3, {16'd0, n});
    endtask

    // Records outputs for ncyc cycles, optionally issuing up to two writes.
    task automatic capture(input int ncyc,
                           input int k1, input logic [2:0] a1, input logic [31:0] d1,
                           input int k2, input logic [2:0] a2, input logic [31:0] d2);
        for (int k = 1; k <= ncyc; k++) begin
            if (k == k1) begin
                address = a1; writedata = d1; chipselect = 1'b1; write_n = 1'b0;
            end else if (k == k2) begin
                address = a2; writedata = d2; chipselect = 1'b1; write_n = 1'b0;
            end else begin
                chipselect = 1'b0; write_n = 1'b1;
            end
            obs_v[k] = {busy, x_valid, done, x_out};
            @(posedge clk);
            #1;
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Reference: iterate the map arithmetically, then lay out the documented
    // cycle timeline (2 cycles per iterate, done with the final iterate).
    task automatic model_run(input logic [15:0] x0, input logic [15:0] r,
                             input int n, input int ncyc);
        int seq [0:40];
        int t;
        int j;
        logic b, v, dn;
        seq[0] = int'(x0);
        for (int i = 1; i <= n; i++) begin
            t      = (seq[i-1] * (65536 - seq[i-1])) / 65536;
            seq[i] = ((int'(r) * t) / 16384) % 65536;
        end
        for (int k = 1; k <= ncyc; k++) begin
            j = (k - 1) / 2;
            if (j > n) j = n;
            b  = (n > 0) && (k <= 2 * n);
            v  = (n > 0) && (k % 2 == 1) && (k >= 3) && (k <= 2 * n + 1);
            dn = (k >= 2 * n + 1);
            exp_v[k] = {b, v, dn, 16'(seq[j])};
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++;
        if ({busy, x_valid, done, x_out, readdata} !== 51'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b xv=%b done=%b x=%h rd=%h exp all 0",
                     busy, x_valid, done, x_out, readdata);
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            checks++;
            if (rd !== 32'd0) begin
                errors++;
                $display("FAIL reset_read addr%0d got %h exp 00000000", a, rd);
            end
        end
    endtask

    task automatic test_single;
        logic [31:0] rd;
        setup_run(16'h8000, 16'h4000, 16'd1);
        bus_write(3'd0, 32'h1);
        capture(5, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0);
        model_run(16'h8000, 16'h4000, 1, 5);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL single cyc%0d {busy,xv,done,x} got %h exp %h", k, obs_v[k], exp_v[k]);
            end
        end
        bus_read(3'd4, rd);
        checks++;
        if (rd !== 32'h4000) begin errors++; $display("FAIL single_result got %h exp 00004000", rd); end
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL single_iter got %h exp 00000001", rd); end
        bus_read(3'd0, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL single_ctrl got %h exp 00000001", rd); end
    endtask

    task automatic test_max_gain;
        logic [31:0] rd;
        setup_run(16'h8000, 16'hFFFF, 16'd2);
        bus_write(3'd0, 32'h1);
        capture(7, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0);
        model_run(16'h8000, 16'hFFFF, 2, 7);
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL maxgain cyc%0d {busy,xv,done,x} got %h exp %h", k, obs_v[k], exp_v[k]);
            end
        end
        checks++;
        if (obs_v[3][15:0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL maxgain_first got %h exp ffff", obs_v[3][15:0]);
        end
        bus_read(3'd4, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL maxgain_result got %h exp 00000000", rd); end
    endtask

    task automatic test_zero;
        logic [31:0] rd;
        setup_run(16'h0000, 16'h3A00, 16'd3);
        bus_write(3'd0, 32'h1);
        capture(9, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0);
        model_run(16'h0000, 16'h3A00, 3, 9);
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL fixedpt cyc%0d {busy,xv,done,x} got %h exp %h", k, obs_v[k], exp_v[k]);
            end
        end
        setup_run(16'hABCD, 16'h3A00, 16'd0);
        bus_write(3'd0, 32'h1);
        capture(3, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0);
        model_run(16'hABCD, 16'h3A00, 0, 3);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL count0 cyc%0d {busy,xv,done,x} got %h exp %h", k, obs_v[k], exp_v[k]);
            end
        end
        bus_read(3'd4, rd);
        checks++;
        if (rd !== 32'hABCD) begin errors++; $display("FAIL count0_result got %h exp 0000abcd", rd); end
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL count0_iter got %h exp 00000000", rd); end
    endtask

    task automatic test_busy;
        logic [31:0] rd;
        setup_run(16'h3000, 16'h3C00, 16'd4);
        bus_write(3'd0, 32'h1);
        capture(11, 2, 3'd1, 32'h1234, 3, 3'd0, 32'h3);
        model_run(16'h3000, 16'h3C00, 4, 11);
        for (int k = 1; k <= 11; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL busyprot cyc%0d {busy,xv,done,x} got %h exp %h", k, obs_v[k], exp_v[k]);
            end
        end
        bus_read(3'd1, rd);
        checks++;
        if (rd !== 32'h1234) begin errors++; $display("FAIL busyprot_x0 got %h exp 00001234", rd); end
        bus_write(3'd0, 32'h1);
        capture(11, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0);
        model_run(16'h1234, 16'h3C00, 4, 11);
        for (int k = 1; k <= 11; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL restart cyc%0d {busy,xv,done,x} got %h exp %h", k, obs_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_done;
        logic [31:0] rd;
        bus_write(3'd0, 32'h2);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL clrdone got done=%b busy=%b exp done=0 busy=0", done, busy);
        end
        bus_read(3'd0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL clrdone_ctrl got %h exp 00000000", rd); end
        bus_write(3'd3, 32'h0);
        bus_write(3'd0, 32'h1);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL setdone got done=%b exp 1", done); end
        setup_run(16'h6000, 16'h3800, 16'd2);
        bus_write(3'd0, 32'h3);
        capture(7, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0);
        model_run(16'h6000, 16'h3800, 2, 7);
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL startclr cyc%0d {busy,xv,done,x} got %h exp %h", k, obs_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_reset_midrun;
        logic [31:0] rd;
        logic        seen;
        setup_run(16'h9000, 16'h3F00, 16'd100);
        bus_write(3'd0, 32'h1);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++;
        if ({busy, x_valid, done, x_out, readdata} !== 51'd0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b xv=%b done=%b x=%h rd=%h exp all 0",
                     busy, x_valid, done, x_out, readdata);
        end
        seen = 1'b0;
        for (int k = 0; k < 250; k++) begin
            if (done || x_valid || busy) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet got activity=%b exp 0", seen);
        end
        for (int a = 0; a < 6; a++) begin
            bus_read(3'(a), rd);
            checks++;
            if (rd !== 32'd0) begin
                errors++;
                $display("FAIL midreset_read addr%0d got %h exp 00000000", a, rd);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] rd;
        logic [15:0] x0, r;
        int          n, nc;
        for (int run = 0; run < 8; run++) begin
            x0 = 16'($urandom_range(0, 65535));
            r  = 16'($urandom_range(0, 65535));
            n  = int'($urandom_range(1, 20));
            nc = 2 * n + 3;
            setup_run(x0, r, 16'(n));
            bus_write(3'd0, 32'h1);
            capture(nc, 0, 3'd0, 32'd0, 0, 3'd0, 32'd0);
            model_run(x0, r, n, nc);
            for (int k = 1; k <= nc; k++) begin
                checks++;
                if (obs_v[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL random run%0d cyc%0d {busy,xv,done,x} got %h exp %h",
                             run, k, obs_v[k], exp_v[k]);
                end
            end
            bus_read(3'd5, rd);
            checks++;
            if (rd !== 32'(n)) begin errors++; $display("FAIL random_iter run%0d got %h exp %h", run, rd, n); end
            bus_read(3'd4, rd);
            checks++;
            if (rd !== {16'd0, exp_v[nc][15:0]}) begin
                errors++;
                $display("FAIL random_result run%0d got %h exp %h", run, rd, exp_v[nc][15:0]);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        test_reset();
        test_single();
        test_max_gain();
        test_zero();
        test_busy();
        test_done();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
